// File: rtl/tx_probe_arbiter_if.sv
// Word-wide push interface shared by the data stream, the probe stream and
// the tx queue input: the master drives data/ctrl/wr, the slave answers with rdy.
interface tx_probe_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] data;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  wr;
    logic                  rdy;

    modport master (output data, output ctrl, output wr, input rdy);
    modport slave  (input data, input ctrl, input wr, output rdy);
endinterface

// File: rtl/tx_probe_arbiter.sv
// Packet-granular arbiter between the data stream and the RTT probe stream in
// front of the tx queue, with a programmable probe timer and send/miss statistics.
module tx_probe_arbiter #(
    parameter int DATA_WIDTH   = 64,
    parameter int CTRL_WIDTH   = DATA_WIDTH / 8,
    parameter int PERIOD_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    tx_probe_arbiter_if.slave       dat,
    input  logic                    dat_pkt_avail,
    tx_probe_arbiter_if.slave       prb,
    input  logic                    prb_pkt_avail,
    output logic                    probe_req,
    tx_probe_arbiter_if.master      out,
    input  logic                    arb_en,
    input  logic [PERIOD_WIDTH-1:0] probe_period,
    output logic [31:0]             probes_sent,
    output logic [31:0]             data_pkts_sent,
    output logic [15:0]             probes_missed
);

    localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE = PERIOD_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        FWD_DATA,
        FWD_PROBE
    } state_t;

    state_t                  state;
    logic [PERIOD_WIDTH-1:0] timer;
    logic                    probe_due;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [CTRL_WIDTH-1:0]   ctrl_q;
    logic                    wr_q;

    logic dat_acc;
    logic prb_acc;
    logic dat_eop;
    logic prb_eop;
    logic timer_run;
    logic expire;

    // Ready follows the tx queue combinationally; the queue absorbs the one word in flight.
    assign dat.rdy   = (state == FWD_DATA) && out.rdy;
    assign prb.rdy   = (state == FWD_PROBE) && out.rdy;
    assign dat_acc   = dat.wr && dat.rdy;
    assign prb_acc   = prb.wr && prb.rdy;
    assign dat_eop   = dat_acc && (|dat.ctrl);
    assign prb_eop   = prb_acc && (|prb.ctrl);

    assign timer_run = arb_en && (probe_period != '0);
    assign expire    = timer_run && (timer == probe_period - PERIOD_ONE);
    assign probe_req = expire && (!probe_due || prb_eop);

    assign out.data  = data_q;
    assign out.ctrl  = ctrl_q;
    assign out.wr    = wr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            data_q         <= '0;
            ctrl_q         <= '0;
            wr_q           <= 1'b0;
            probes_sent    <= '0;
            data_pkts_sent <= '0;
        end else begin
            wr_q <= dat_acc || prb_acc;
            if (prb_acc) begin
                data_q <= prb.data;
                ctrl_q <= prb.ctrl;
            end else if (dat_acc) begin
                data_q <= dat.data;
                ctrl_q <= dat.ctrl;
            end

            case (state)
                IDLE: begin
                    // A built probe only wins once the timer has made it due.
                    if (arb_en) begin
                        if (probe_due && prb_pkt_avail) begin
                            state <= FWD_PROBE;
                        end else if (dat_pkt_avail) begin
                            state <= FWD_DATA;
                        end
                    end
                end
                FWD_DATA: begin
                    if (dat_eop) begin
                        state          <= IDLE;
                        data_pkts_sent <= data_pkts_sent + 32'd1;
                    end
                end
                FWD_PROBE: begin
                    if (prb_eop) begin
                        state       <= IDLE;
                        probes_sent <= probes_sent + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer         <= '0;
            probe_due     <= 1'b0;
            probes_missed <= '0;
        end else begin
            // A period lowered below the running count restarts the timer silently.
            if (timer_run) begin
                if (expire || (timer >= probe_period)) begin
                    timer <= '0;
                end else begin
                    timer <= timer + PERIOD_ONE;
                end
            end

            if (expire) begin
                probe_due <= 1'b1;
            end else if (prb_eop) begin
                probe_due <= 1'b0;
            end

            if (expire && probe_due && !prb_eop && (probes_missed != 16'hFFFF)) begin
                probes_missed <= probes_missed + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tx_probe_arbiter.sv
// Directed bench for tx_probe_arbiter: stimulus pushes expected words into a
// scoreboard queue that a separate output monitor pops and compares.
module tb_tx_probe_arbiter;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int PW = 32;
    localparam int WW = DW + CW;

    logic          clk = 1'b0;
    logic          reset;
    logic          dat_pkt_avail;
    logic          prb_pkt_avail;
    logic          probe_req;
    logic          arb_en;
    logic [PW-1:0] probe_period;
    logic [31:0]   probes_sent;
    logic [31:0]   data_pkts_sent;
    logic [15:0]   probes_missed;

    tx_probe_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dat_if ();
    tx_probe_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) prb_if ();
    tx_probe_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) out_if ();

    tx_probe_arbiter #(
        .DATA_WIDTH(DW),
        .CTRL_WIDTH(CW),
        .PERIOD_WIDTH(PW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .dat(dat_if),
        .dat_pkt_avail(dat_pkt_avail),
        .prb(prb_if),
        .prb_pkt_avail(prb_pkt_avail),
        .probe_req(probe_req),
        .out(out_if),
        .arb_en(arb_en),
        .probe_period(probe_period),
        .probes_sent(probes_sent),
        .data_pkts_sent(data_pkts_sent),
        .probes_missed(probes_missed)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          req_count = 0;
    int          en_cycle = 0;
    logic [WW-1:0] exp_q[$];
    logic [7:0]  order_q[$];
    bit          mid_pkt = 1'b0;
    bit          toggle_rdy = 1'b0;

    always @(posedge clk) cycle++;

    task automatic check_output(input string name, input logic [WW-1:0] actual,
                                input logic [WW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Output monitor: every word written to the tx queue must be the next one expected.
    always @(negedge clk) begin : monitor
        logic [WW-1:0] exp_word;
        if (reset) mid_pkt = 1'b0;
        if (probe_req === 1'b1) req_count++;
        if (out_if.wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_word: got %0h expected none", {out_if.ctrl, out_if.data});
            end else begin
                exp_word = exp_q.pop_front();
                check_output("out_word", {out_if.ctrl, out_if.data}, exp_word);
                if (!mid_pkt) order_q.push_back(out_if.data[63:56]);
                mid_pkt = (out_if.ctrl == '0);
            end
        end
    end

    // The tx queue side: ready held high, or toggled every cycle when requested.
    initial begin
        out_if.rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_if.rdy = toggle_rdy ? ~out_if.rdy : 1'b1;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Pushes one packet from the chosen source, writing only while its rdy is high.
    // abort_at>0 asserts reset together with that word and returns immediately.
    task automatic apply_stimulus(input bit is_probe, input int n_words, input int pkt_id,
                                  input int abort_at);
        int            i = 0;
        int            budget = 0;
        bit            rdy;
        logic [DW-1:0] w;
        logic [CW-1:0] c;
        while (i < n_words) begin
            @(negedge clk);
            if (budget > 300) begin
                checks++;
                errors++;
                $display("[TB] FAIL grant_timeout: got no rdy for pkt %0d expected grant", pkt_id);
                break;
            end
            budget++;
            rdy = is_probe ? prb_if.rdy : dat_if.rdy;
            w   = {(is_probe ? 8'hA0 : 8'hD0), 24'(pkt_id), 32'(i)};
            c   = (i == n_words - 1) ? CW'(1) : '0;
            if (is_probe) begin
                prb_if.data = w;
                prb_if.ctrl = c;
                prb_if.wr   = rdy;
            end else begin
                dat_if.data = w;
                dat_if.ctrl = c;
                dat_if.wr   = rdy;
            end
            if (rdy) begin
                if (abort_at != 0 && i == abort_at - 1) begin
                    reset = 1'b1;
                    return;
                end
                exp_q.push_back({c, w});
                i++;
            end
        end
        @(negedge clk);
        dat_if.wr = 1'b0;
        prb_if.wr = 1'b0;
    endtask

    task automatic wait_probe_req();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (probe_req !== 1'b1 && n < 150);
        if (probe_req !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL probe_req_timeout: got 0 expected pulse");
        end
    endtask

    task automatic do_reset();
        arb_en        = 1'b0;
        dat_pkt_avail = 1'b0;
        prb_pkt_avail = 1'b0;
        probe_period  = '0;
        reset         = 1'b1;
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        req_count = 0;
        order_q.delete();
    endtask

    initial begin
        reset         = 1'b1;
        arb_en        = 1'b0;
        probe_period  = '0;
        dat_pkt_avail = 1'b0;
        prb_pkt_avail = 1'b0;
        dat_if.wr = 1'b0; dat_if.data = '0; dat_if.ctrl = '0;
        prb_if.wr = 1'b0; prb_if.data = '0; prb_if.ctrl = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check_output("rst_out_wr", WW'(out_if.wr), WW'(0));
        check_output("rst_out_word", {out_if.ctrl, out_if.data}, WW'(0));
        check_output("rst_counters", WW'({probes_sent, data_pkts_sent}), WW'(0));
        check_output("rst_missed", WW'(probes_missed), WW'(0));
        check_output("rst_rdy_req", WW'({dat_if.rdy, prb_if.rdy, probe_req}), WW'(0));

        // Disabled arbiter: writes are dropped and no grant is made.
        dat_pkt_avail = 1'b1;
        dat_if.wr = 1'b1; dat_if.data = 64'hDEAD; dat_if.ctrl = CW'(1);
        prb_if.wr = 1'b1; prb_if.data = 64'hBEEF; prb_if.ctrl = CW'(1);
        repeat (3) @(negedge clk);
        check_output("dropped_wr", WW'(out_if.wr), WW'(0));
        check_output("disabled_rdy", WW'(dat_if.rdy), WW'(0));
        dat_if.wr = 1'b0;
        prb_if.wr = 1'b0;

        // Three back-to-back 4-word data packets with probing disabled.
        req_count = 0;
        arb_en    = 1'b1;
        for (int p = 0; p < 3; p++) begin
            apply_stimulus(1'b0, 4, p, 0);
        end
        dat_pkt_avail = 1'b0;
        repeat (2) @(negedge clk);
        check_output("t1_data_pkts", WW'(data_pkts_sent), WW'(3));
        check_output("t1_probe_req", WW'(req_count), WW'(0));
        check_output("t1_drained", WW'(exp_q.size()), WW'(0));

        // Period 100: pulses 99/199/299 cycles after enable, probe built 5 cycles later.
        do_reset();
        probe_period = 100;
        arb_en       = 1'b1;
        en_cycle     = cycle;
        for (int j = 0; j < 3; j++) begin
            wait_probe_req();
            check_output("t2_req_cycle", WW'(cycle - en_cycle), WW'(99 + 100 * j));
            repeat (5) @(negedge clk);
            prb_pkt_avail = 1'b1;
            apply_stimulus(1'b1, 2, 100 + j, 0);
            prb_pkt_avail = 1'b0;
        end
        arb_en = 1'b0;
        check_output("t2_probes_sent", WW'(probes_sent), WW'(3));
        check_output("t2_missed", WW'(probes_missed), WW'(0));
        check_output("t2_req_count", WW'(req_count), WW'(3));

        // Probe due mid data packet: data finishes, probe next, then data resumes.
        do_reset();
        probe_period  = 7;
        prb_pkt_avail = 1'b1;
        dat_pkt_avail = 1'b1;
        arb_en        = 1'b1;
        apply_stimulus(1'b0, 8, 10, 0);
        apply_stimulus(1'b1, 2, 11, 0);
        prb_pkt_avail = 1'b0;
        apply_stimulus(1'b0, 4, 12, 0);
        dat_pkt_avail = 1'b0;
        arb_en        = 1'b0;
        repeat (2) @(negedge clk);
        check_output("t3_order_len", WW'(order_q.size()), WW'(3));
        if (order_q.size() == 3) begin
            check_output("t3_order", WW'({order_q[0], order_q[1], order_q[2]}), WW'(24'hD0A0D0));
        end
        check_output("t3_counts", WW'({probes_sent, data_pkts_sent}), WW'({32'd1, 32'd2}));
        check_output("t3_req_count", WW'(req_count), WW'(2));
        check_output("t3_missed", WW'(probes_missed), WW'(0));

        // Period 3: each probe EOP coincides with an expiry, so the probe stays due.
        do_reset();
        probe_period  = 3;
        prb_pkt_avail = 1'b1;
        arb_en        = 1'b1;
        apply_stimulus(1'b1, 2, 20, 0);
        apply_stimulus(1'b1, 2, 21, 0);
        prb_pkt_avail = 1'b0;
        arb_en        = 1'b0;
        repeat (2) @(negedge clk);
        check_output("t3b_req_count", WW'(req_count), WW'(3));
        check_output("t3b_missed", WW'(probes_missed), WW'(0));
        check_output("t3b_probes_sent", WW'(probes_sent), WW'(2));

        // Period 10, no probe for 35 cycles: one pulse, two misses, probe still due.
        do_reset();
        probe_period = 10;
        arb_en       = 1'b1;
        repeat (35) @(negedge clk);
        check_output("t4_req_count", WW'(req_count), WW'(1));
        check_output("t4_missed", WW'(probes_missed), WW'(2));
        prb_pkt_avail = 1'b1;
        apply_stimulus(1'b1, 2, 30, 0);
        prb_pkt_avail = 1'b0;
        arb_en        = 1'b0;
        check_output("t4_due_grant", WW'(probes_sent), WW'(1));

        // out_rdy toggling every cycle during a 6-word data packet.
        do_reset();
        toggle_rdy    = 1'b1;
        dat_pkt_avail = 1'b1;
        arb_en        = 1'b1;
        apply_stimulus(1'b0, 6, 40, 0);
        dat_pkt_avail = 1'b0;
        toggle_rdy    = 1'b0;
        repeat (3) @(negedge clk);
        check_output("t5_drained", WW'(exp_q.size()), WW'(0));
        check_output("t5_data_pkts", WW'(data_pkts_sent), WW'(1));

        // Reset on the 3rd word of a 6-word packet, then a clean packet.
        dat_pkt_avail = 1'b1;
        apply_stimulus(1'b0, 6, 50, 3);
        @(negedge clk);
        check_output("t6_out_wr", WW'(out_if.wr), WW'(0));
        check_output("t6_out_word", {out_if.ctrl, out_if.data}, WW'(0));
        check_output("t6_counters", WW'({probes_sent, data_pkts_sent, probes_missed}), WW'(0));
        check_output("t6_idle_rdy", WW'(dat_if.rdy), WW'(0));
        dat_if.wr = 1'b0;
        reset     = 1'b0;
        apply_stimulus(1'b0, 6, 51, 0);
        dat_pkt_avail = 1'b0;
        arb_en        = 1'b0;
        repeat (3) @(negedge clk);
        check_output("t6_data_pkts", WW'(data_pkts_sent), WW'(1));
        check_output("t6_drained", WW'(exp_q.size()), WW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
